// File: rtl/fp_sub_iter.sv
// fp_sub_iter: multi-cycle binary32 subtractor fp_result = fp_a - fp_b with one serial 1-bit/clk shifter
//   in:  clk, rst_n (async, active low), in_valid, fp_a, fp_b, r_mode (000 RNE,001 RTZ,010 RDN,011 RUP,100 RMM), out_ready
//   out: in_ready, out_valid, fp_result, overflow, underflow, invalid (only with FP_SUB_SPECIAL_EN)
//   FP_SUB_SPECIAL_EN: Inf/NaN operands bypass the datapath and the invalid port is added.
module fp_sub_iter #(
  parameter int ALIGN_MAX = 27,
  parameter int RMODE_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        fp_a,
  input  logic [31:0]        fp_b,
  input  logic [RMODE_W-1:0] r_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        fp_result,
  output logic               overflow,
`ifdef FP_SUB_SPECIAL_EN
  output logic               invalid,
`endif
  output logic               underflow
);
  localparam logic [RMODE_W-1:0] RNE = 0, RDN = 2, RUP = 3, RMM = 4;
  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, SUB, NORM, ROUND, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [RMODE_W-1:0] rm_q, rm_d;
  logic sign_q, sign_d, esub_q, esub_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [8:0] exp_q, exp_d;
  logic [26:0] ma_q, ma_d, mb_q, mb_d;
  logic [7:0] diff_q, diff_d, cnt_q, cnt_d;
`ifdef FP_SUB_SPECIAL_EN
  logic inv_q, inv_d;
  logic a_inf, b_inf, a_nan, b_nan;
  assign a_inf = &a_q[30:23];
  assign b_inf = &b_q[30:23];
  assign a_nan = a_inf & |a_q[22:0];
  assign b_nan = b_inf & |b_q[22:0];
  assign invalid = inv_q;
`endif
  // b_q already carries the flipped sign, so the whole op is an addition of a_q and b_q
  logic a_big;
  logic [31:0] x;
  logic [30:0] y;
  logic [7:0] ex, ey;
  logic [27:0] sum;
  logic g, rs, inc, hid, ovf_r, inf_r;
  logic [24:0] rnd;
  logic [8:0] e_fin;
  assign a_big = a_q[30:0] >= b_q[30:0];
  assign x = a_big ? a_q : b_q;
  assign y = a_big ? b_q[30:0] : a_q[30:0];
  assign ex = |x[30:23] ? x[30:23] : 8'd1;
  assign ey = |y[30:23] ? y[30:23] : 8'd1;
  assign sum = esub_q ? {1'b0, ma_q} - {1'b0, mb_q} : {1'b0, ma_q} + {1'b0, mb_q};
  assign g = ma_q[2];
  assign rs = ma_q[1] | ma_q[0];
  assign inc = rm_q == RNE ? g & (rs | ma_q[3]) :
               rm_q == RDN ? (g | rs) & sign_q :
               rm_q == RUP ? (g | rs) & ~sign_q :
               rm_q == RMM ? g : 1'b0;
  // a carry into bit 24 leaves the fraction zero, and a subnormal carrying into bit 23 becomes normal
  assign rnd = {1'b0, ma_q[26:3]} + {24'd0, inc};
  assign e_fin = exp_q + {8'd0, rnd[24]};
  assign hid = rnd[24] | rnd[23];
  assign ovf_r = hid & (e_fin >= 9'd255);
  assign inf_r = rm_q == RNE || rm_q == RMM || (rm_q == RUP && !sign_q) || (rm_q == RDN && sign_q);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    rm_d = rm_q;
    sign_d = sign_q;
    esub_d = esub_q;
    exp_d = exp_q;
    ma_d = ma_q;
    mb_d = mb_q;
    diff_d = diff_q;
    cnt_d = cnt_q;
    res_d = res_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
`ifdef FP_SUB_SPECIAL_EN
    inv_d = inv_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = fp_a;
        b_d = {~fp_b[31], fp_b[30:0]};
        rm_d = r_mode;
        state_d = UNPACK;
      end
      UNPACK: begin
        sign_d = x[31];
        esub_d = a_q[31] ^ b_q[31];
        exp_d = {1'b0, ex};
        diff_d = ex - ey;
        ma_d = {|x[30:23], x[22:0], 3'b0};
        mb_d = {|y[30:23], y[22:0], 3'b0};
        cnt_d = 8'd0;
        state_d = ALIGN;
`ifdef FP_SUB_SPECIAL_EN
        if (a_inf || b_inf) begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
          inv_d = !(a_nan || b_nan) && a_inf && b_inf && a_q[31] != b_q[31];
          res_d = (a_nan || b_nan || inv_d) ? 32'h7FC00000 : {a_inf ? a_q[31] : b_q[31], 31'h7F800000};
          state_d = DONE;
        end
`endif
      end
      ALIGN: if (diff_q == 8'd0 || cnt_q == 8'(ALIGN_MAX)) state_d = SUB;
      else begin
        mb_d = {1'b0, mb_q[26:2], mb_q[1] | mb_q[0]};
        diff_d = diff_q - 8'd1;
        cnt_d = cnt_q + 8'd1;
      end
      SUB: begin
        state_d = NORM;
        if (sum == 28'd0) begin
          sign_d = rm_q == RDN;
          ma_d = 27'd0;
          state_d = ROUND;
        end else if (sum[27]) begin
          ma_d = {sum[27:2], sum[1] | sum[0]};
          exp_d = exp_q + 9'd1;
        end else ma_d = sum[26:0];
      end
      NORM: if (ma_q[26] || exp_q == 9'd1) state_d = ROUND;
      else begin
        ma_d = {ma_q[25:0], 1'b0};
        exp_d = exp_q - 9'd1;
      end
      ROUND: begin
        ovf_d = ovf_r;
        unf_d = !hid && |rnd[22:0];
        res_d = ovf_r ? (inf_r ? {sign_q, 31'h7F800000} : {sign_q, 31'h7F7FFFFF}) :
                {sign_q, hid ? e_fin[7:0] : 8'd0, rnd[22:0]};
`ifdef FP_SUB_SPECIAL_EN
        inv_d = 1'b0;
`endif
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      rm_q <= '0;
      sign_q <= 1'b0;
      esub_q <= 1'b0;
      exp_q <= '0;
      ma_q <= '0;
      mb_q <= '0;
      diff_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
`ifdef FP_SUB_SPECIAL_EN
      inv_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      rm_q <= rm_d;
      sign_q <= sign_d;
      esub_q <= esub_d;
      exp_q <= exp_d;
      ma_q <= ma_d;
      mb_q <= mb_d;
      diff_q <= diff_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
`ifdef FP_SUB_SPECIAL_EN
      inv_q <= inv_d;
`endif
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign fp_result = res_q;
  assign overflow = ovf_q;
  assign underflow = unf_q;
endmodule
